// File: rtl/uart_cmd_decoder_pkg.sv
// Shared definitions for the UART command decoder.
// Holds FSM encodings, command characters and class indices.
package uart_cmd_decoder_pkg;

    localparam int MODE_W = 5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ACK  = 2'd2;

    localparam logic [7:0] CH_U  = 8'h55;
    localparam logic [7:0] CH_D  = 8'h44;
    localparam logic [7:0] CH_L  = 8'h4C;
    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_S  = 8'h53;
    localparam logic [7:0] CH_M  = 8'h4D;
    localparam logic [7:0] CH_X  = 8'h58;
    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    localparam logic [7:0] ACK_DEF = 8'h4B;
    localparam logic [7:0] NAK_DEF = 8'h3F;

    // One-hot command class bit positions
    localparam int CL_U    = 0;
    localparam int CL_D    = 1;
    localparam int CL_L    = 2;
    localparam int CL_R    = 3;
    localparam int CL_SET  = 4;
    localparam int CL_MODE = 5;
    localparam int CL_CTRL = 6;
    localparam int CL_CLR  = 7;
    localparam int CL_IGN  = 8;
    localparam int CL_BAD  = 9;
    localparam int CLS_W   = 10;

endpackage

// File: rtl/uart_cmd_decoder_classify.sv
// Combinational byte classifier: case-folds letters and maps a
// command byte to a one-hot class plus the mode bit index.
module uart_cmd_classify
    import uart_cmd_decoder_pkg::*;
(
    input  logic [7:0]       iByte,
    output logic [CLS_W-1:0] oCls,
    output logic [2:0]       oIdx
);

    logic [7:0] fold;

    // Fold lowercase a..z onto uppercase
    always_comb begin
        fold = iByte;
        if (iByte >= 8'h61 && iByte <= 8'h7A) begin
            fold = iByte - 8'h20;
        end
    end

    // Map the folded byte to exactly one class
    always_comb begin
        oCls = '0;
        oIdx = '0;
        case (fold)
            CH_U:  oCls[CL_U]    = 1'b1;
            CH_D:  oCls[CL_D]    = 1'b1;
            CH_L:  oCls[CL_L]    = 1'b1;
            CH_R:  oCls[CL_R]    = 1'b1;
            CH_S:  oCls[CL_SET]  = 1'b1;
            CH_M:  oCls[CL_CTRL] = 1'b1;
            CH_X:  oCls[CL_CLR]  = 1'b1;
            CH_CR, CH_LF:
                   oCls[CL_IGN]  = 1'b1;
            CH_0, CH_0 + 8'd1, CH_0 + 8'd2,
            CH_0 + 8'd3, CH_0 + 8'd4: begin
                oCls[CL_MODE] = 1'b1;
                oIdx = fold[2:0];
            end
            default: oCls[CL_BAD] = 1'b1;
        endcase
    end

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART command decoder: pops ASCII commands from the RX FIFO,
// drives PC-side controls and acknowledges into the TX FIFO.
module uart_cmd_decoder
    import uart_cmd_decoder_pkg::*;
#(
    parameter bit         ECHO_EN  = 1'b1,
    parameter logic [7:0] ACK_CHAR = ACK_DEF,
    parameter logic [7:0] NAK_CHAR = NAK_DEF
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic [7:0]        iRx_Data,
    input  logic              iRx_Empty,
    output logic              oRx_Pop,
    input  logic              iTx_Full,
    output logic [7:0]        oTx_Data,
    output logic              oTx_Push,
    output logic              oCtrl_Mode,
    output logic              oPC_Set,
    output logic [MODE_W-1:0] oPC_Mode,
    output logic              oPC_Btn_U,
    output logic              oPC_Btn_D,
    output logic              oPC_Btn_L,
    output logic              oPC_Btn_R
);

    logic [1:0]        state_q, state_d;
    logic [7:0]        byte_q;
    logic              set_q;
    logic [MODE_W-1:0] mode_q;
    logic              ctrl_q;
    logic [7:0]        tx_q;
    logic [CLS_W-1:0]  cls;
    logic [2:0]        idx;
    logic              exec;
    logic              take;

    uart_cmd_classify u_classify (
        .iByte (byte_q),
        .oCls  (cls),
        .oIdx  (idx)
    );

    assign exec = (state_q == ST_EXEC);
    // Pop is gated by reset so the strobe is silent while held in reset
    assign take = iRst_n && (state_q == ST_IDLE) && !iRx_Empty;

    // Next-state logic for IDLE -> EXEC -> (ACK) -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (!iRx_Empty) state_d = ST_EXEC;
            ST_EXEC: begin
                if (cls[CL_IGN] || !ECHO_EN) state_d = ST_IDLE;
                else                         state_d = ST_ACK;
            end
            ST_ACK:  if (!iTx_Full) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // Latch the FIFO head byte on the pop cycle
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n)   byte_q <= '0;
        else if (take) byte_q <= iRx_Data;
    end

    // Apply decoded command and choose the response byte
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            set_q  <= 1'b0;
            mode_q <= '0;
            ctrl_q <= 1'b0;
            tx_q   <= '0;
        end else if (exec) begin
            if (cls[CL_SET])  set_q  <= ~set_q;
            if (cls[CL_MODE]) mode_q <= mode_q ^ (MODE_W'(1) << idx);
            if (cls[CL_CTRL]) ctrl_q <= ~ctrl_q;
            if (cls[CL_CLR]) begin
                set_q  <= 1'b0;
                mode_q <= '0;
            end
            tx_q <= cls[CL_BAD] ? NAK_CHAR : ACK_CHAR;
        end
    end

    assign oRx_Pop    = take;
    assign oTx_Push   = (state_q == ST_ACK) && !iTx_Full;
    assign oTx_Data   = tx_q;
    assign oCtrl_Mode = ctrl_q;
    assign oPC_Set    = set_q;
    assign oPC_Mode   = mode_q;
    assign oPC_Btn_U  = exec && cls[CL_U];
    assign oPC_Btn_D  = exec && cls[CL_D];
    assign oPC_Btn_L  = exec && cls[CL_L];
    assign oPC_Btn_R  = exec && cls[CL_R];

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Self-checking bench for uart_cmd_decoder: table of single commands
// plus hand sequences for latency, CR, backpressure and reset.
module tb_uart_cmd_decoder;

    logic       iClk = 1'b0;
    logic       iRst_n;
    logic [7:0] iRx_Data;
    logic       iRx_Empty;
    logic       oRx_Pop;
    logic       iTx_Full;
    logic [7:0] oTx_Data;
    logic       oTx_Push;
    logic       oCtrl_Mode;
    logic       oPC_Set;
    logic [4:0] oPC_Mode;
    logic       oPC_Btn_U, oPC_Btn_D, oPC_Btn_L, oPC_Btn_R;

    uart_cmd_decoder dut (
        .iClk       (iClk),
        .iRst_n     (iRst_n),
        .iRx_Data   (iRx_Data),
        .iRx_Empty  (iRx_Empty),
        .oRx_Pop    (oRx_Pop),
        .iTx_Full   (iTx_Full),
        .oTx_Data   (oTx_Data),
        .oTx_Push   (oTx_Push),
        .oCtrl_Mode (oCtrl_Mode),
        .oPC_Set    (oPC_Set),
        .oPC_Mode   (oPC_Mode),
        .oPC_Btn_U  (oPC_Btn_U),
        .oPC_Btn_D  (oPC_Btn_D),
        .oPC_Btn_L  (oPC_Btn_L),
        .oPC_Btn_R  (oPC_Btn_R)
    );

    always #5 iClk = ~iClk;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [7:0] rxq[$];
    logic [7:0] txlog[$];
    logic       pop_n = 1'b0;
    logic [3:0] btn_acc;
    int         btn_cnt;
    logic [3:0] btn_v;

    typedef struct {
        logic [7:0] b;
        logic [3:0] btn;
        logic       set;
        logic [4:0] mode;
        logic       ctrl;
        logic       push;
        logic [7:0] tx;
    } vec_t;

    vec_t vt[16];

    task automatic upd();
        iRx_Empty = (rxq.size() == 0);
        iRx_Data  = iRx_Empty ? 8'h00 : rxq[0];
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        upd();
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic neg();
        @(negedge iClk);
        #1;
    endtask

    task automatic pos();
        @(posedge iClk);
        #1;
    endtask

    // Observe outputs mid-cycle: log pushes, track pulses, check invariants
    always @(negedge iClk) begin
        pop_n = oRx_Pop;
        btn_v = {oPC_Btn_U, oPC_Btn_D, oPC_Btn_L, oPC_Btn_R};
        btn_acc = btn_acc | btn_v;
        btn_cnt += $countones(btn_v);
        if (oTx_Push) txlog.push_back(oTx_Data);
        n_assert++;
        if ((oRx_Pop && iRx_Empty) || (oTx_Push && iTx_Full) ||
            ($countones(btn_v) > 1)) begin
            n_fail++;
            $display("FAIL protocol: pop=%0b empty=%0b push=%0b full=%0b btn=%b",
                     oRx_Pop, iRx_Empty, oTx_Push, iTx_Full, btn_v);
        end
    end

    // RX FIFO model: remove the head after a popped cycle
    always @(posedge iClk) begin
        #1;
        if (pop_n && rxq.size() > 0) void'(rxq.pop_front());
        pop_n = 1'b0;
        upd();
    end

    task automatic run_cmd(input vec_t v, input int k);
        int t0;
        pos();
        btn_acc = '0;
        btn_cnt = 0;
        t0 = txlog.size();
        push_rx(v.b);
        repeat (4) neg();
        chk($sformatf("v%0d btn", k), 32'(btn_acc), 32'(v.btn));
        chk($sformatf("v%0d btn_cycles", k), btn_cnt,
            32'($countones(v.btn)));
        chk($sformatf("v%0d set", k), 32'(oPC_Set), 32'(v.set));
        chk($sformatf("v%0d mode", k), 32'(oPC_Mode), 32'(v.mode));
        chk($sformatf("v%0d ctrl", k), 32'(oCtrl_Mode), 32'(v.ctrl));
        chk($sformatf("v%0d pushes", k), txlog.size() - t0, 32'(v.push));
        if (v.push && txlog.size() > t0)
            chk($sformatf("v%0d txdata", k), 32'(txlog[$]), 32'(v.tx));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int t0;
        // {byte, {U,D,L,R}, set, mode, ctrl, push, tx}
        vt[0]  = '{8'h55, 4'b1000, 0, 5'b00000, 0, 1, 8'h4B};
        vt[1]  = '{8'h64, 4'b0100, 0, 5'b00000, 0, 1, 8'h4B};
        vt[2]  = '{8'h6C, 4'b0010, 0, 5'b00000, 0, 1, 8'h4B};
        vt[3]  = '{8'h52, 4'b0001, 0, 5'b00000, 0, 1, 8'h4B};
        vt[4]  = '{8'h32, 4'b0000, 0, 5'b00100, 0, 1, 8'h4B};
        vt[5]  = '{8'h34, 4'b0000, 0, 5'b10100, 0, 1, 8'h4B};
        vt[6]  = '{8'h6D, 4'b0000, 0, 5'b10100, 1, 1, 8'h4B};
        vt[7]  = '{8'h32, 4'b0000, 0, 5'b10000, 1, 1, 8'h4B};
        vt[8]  = '{8'h73, 4'b0000, 1, 5'b10000, 1, 1, 8'h4B};
        vt[9]  = '{8'h58, 4'b0000, 0, 5'b00000, 1, 1, 8'h4B};
        vt[10] = '{8'h41, 4'b0000, 0, 5'b00000, 1, 1, 8'h3F};
        vt[11] = '{8'h0D, 4'b0000, 0, 5'b00000, 1, 0, 8'h00};
        vt[12] = '{8'h0A, 4'b0000, 0, 5'b00000, 1, 0, 8'h00};
        vt[13] = '{8'h30, 4'b0000, 0, 5'b00001, 1, 1, 8'h4B};
        vt[14] = '{8'h35, 4'b0000, 0, 5'b00001, 1, 1, 8'h3F};
        vt[15] = '{8'h4D, 4'b0000, 0, 5'b00001, 0, 1, 8'h4B};

        iRst_n = 1'b0;
        iTx_Full = 1'b0;
        btn_acc = '0;
        btn_cnt = 0;
        upd();
        repeat (3) pos();
        neg();
        chk("reset outputs",
            {oRx_Pop, oTx_Push, oTx_Data, oCtrl_Mode, oPC_Set, oPC_Mode,
             oPC_Btn_U, oPC_Btn_D, oPC_Btn_L, oPC_Btn_R}, 32'd0);
        pos();
        iRst_n = 1'b1;
        neg();
        chk("idle no pop/push", {oRx_Pop, oTx_Push}, 32'd0);

        // 'U' latency: pop c0, pulse c1 only, ack c2
        pos();
        t0 = txlog.size();
        push_rx(8'h55);
        neg();
        chk("U c0 pop", oRx_Pop, 1);
        chk("U c0 btn", oPC_Btn_U, 0);
        neg();
        chk("U c1 btn", oPC_Btn_U, 1);
        chk("U c1 pop", oRx_Pop, 0);
        neg();
        chk("U c2 btn", oPC_Btn_U, 0);
        chk("U c2 push", oTx_Push, 1);
        chk("U c2 data", oTx_Data, 8'h4B);
        neg();
        chk("U c3 push", oTx_Push, 0);
        chk("U pushes", txlog.size() - t0, 1);

        for (int i = 0; i < 16; i++) run_cmd(vt[i], i);

        // CR then U: CR takes 2 cycles with no ack, U popped at c2
        pos();
        t0 = txlog.size();
        push_rx(8'h0D);
        push_rx(8'h55);
        neg();
        chk("CR c0 pop", oRx_Pop, 1);
        neg();
        chk("CR c1 pop", oRx_Pop, 0);
        chk("CR c1 push", oTx_Push, 0);
        neg();
        chk("CR c2 pop", oRx_Pop, 1);
        chk("CR no push", txlog.size() - t0, 0);
        neg();
        chk("CR c3 btnU", oPC_Btn_U, 1);
        neg();
        chk("CR c4 push", oTx_Push, 1);

        // Backpressure: D, S queued with TX full for 5 ACK cycles
        pos();
        iTx_Full = 1'b1;
        t0 = txlog.size();
        push_rx(8'h44);
        push_rx(8'h53);
        neg();
        chk("bp c0 pop", oRx_Pop, 1);
        neg();
        chk("bp c1 btnD", oPC_Btn_D, 1);
        for (int c = 2; c < 7; c++) begin
            neg();
            chk($sformatf("bp c%0d push", c), oTx_Push, 0);
            chk($sformatf("bp c%0d pop", c), oRx_Pop, 0);
        end
        pos();
        iTx_Full = 1'b0;
        neg();
        chk("bp c7 push", oTx_Push, 1);
        chk("bp c7 data", oTx_Data, 8'h4B);
        neg();
        chk("bp c8 pop", oRx_Pop, 1);
        chk("bp c8 set", oPC_Set, 0);
        neg();
        neg();
        chk("bp c10 set", oPC_Set, 1);
        chk("bp c10 push", oTx_Push, 1);
        chk("bp pushes", txlog.size() - t0, 2);

        // Bring Set back to 0, then reset during EXEC of 'S'
        run_cmd('{8'h53, 4'b0000, 0, 5'b00001, 0, 1, 8'h4B}, 16);
        pos();
        t0 = txlog.size();
        push_rx(8'h53);
        neg();
        chk("rst c0 pop", oRx_Pop, 1);
        @(negedge iClk);
        iRst_n = 1'b0;
        #1;
        chk("rst set", oPC_Set, 0);
        repeat (2) pos();
        iRst_n = 1'b1;
        neg();
        neg();
        chk("rst set after", oPC_Set, 0);
        chk("rst no ack", txlog.size() - t0, 0);
        pos();
        push_rx(8'h55);
        neg();
        chk("rst idle pop", oRx_Pop, 1);
        repeat (4) neg();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_decoder.md
Name: uart_cmd_decoder

Overview:
- Decodes ASCII command bytes from the UART RX FIFO into PC-side control signals: Set level, 5-bit mode switches, U/D/L/R button pulses and the PC/FPGA control-select bit.
- Its outputs feed the PC inputs and select input of the PC/FPGA control mux.
- Acknowledges each accepted byte by pushing a response character into the UART TX FIFO.

Parameters:
- ECHO_EN, 1, 1 = push an ack or nack byte per decoded command; 0 = no TX traffic.
- ACK_CHAR, 8'h4B ('K'), byte pushed after a recognised command.
- NAK_CHAR, 8'h3F ('?'), byte pushed after an unrecognised byte.

Ports:
- iClk  in  1  system clock.
- iRst_n  in  1  reset, asynchronous, active-low.
- iRx_Data  in  8  head byte of the first-word-fall-through RX FIFO; valid while iRx_Empty=0.
- iRx_Empty  in  1  RX FIFO empty.
- oRx_Pop  out  1  one-cycle pop strobe.
- iTx_Full  in  1  TX FIFO full.
- oTx_Data  out  8  byte to TX FIFO.
- oTx_Push  out  1  one-cycle push strobe.
- oCtrl_Mode  out  1  control select to the mux: 1 = PC, 0 = FPGA.
- oPC_Set  out  1  PC Set level.
- oPC_Mode  out  5  PC mode switch bits.
- oPC_Btn_U, oPC_Btn_D, oPC_Btn_L, oPC_Btn_R  out  1 each  one-cycle button pulses.

Behaviour:
- Reset: iRst_n=0 asynchronously clears every output to 0 and forces the FSM to IDLE. oCtrl_Mode=0, so the FPGA buttons control the design after reset.
- Reset mid-command: the latched byte is discarded, no pulse fires, no ack is pushed.
- FSM states: IDLE, EXEC, ACK.
- IDLE:
  - If iRx_Empty=0, latch iRx_Data, assert oRx_Pop for exactly that cycle, then go to EXEC.
  - Otherwise stay in IDLE with oRx_Pop=0.
- EXEC (one cycle): decode the latched byte. Letters are case-insensitive.
  - 'U'/'D'/'L'/'R': matching oPC_Btn_* = 1 for this cycle only.
  - 'S': toggle oPC_Set.
  - '0'..'4': toggle oPC_Mode[n], where n is the digit value.
  - 'M': toggle oCtrl_Mode.
  - 'X': clear oPC_Set and oPC_Mode to 0; oCtrl_Mode unchanged.
  - CR (8'h0D), LF (8'h0A): ignored; go straight to IDLE with no ack.
  - Any other byte: no state change; flagged for NAK.
  - Next state: ACK if ECHO_EN=1 and the byte was not CR/LF; otherwise IDLE.
  - Register updates take effect on the EXEC clock edge, so they are visible in the cycle after EXEC.
- ACK:
  - If iTx_Full=0, assert oTx_Push for one cycle with oTx_Data = ACK_CHAR (recognised) or NAK_CHAR (unrecognised), then go to IDLE.
  - If iTx_Full=1, hold in ACK with oTx_Push=0 and no RX pops until space frees.
  - oTx_Data holds its value while waiting.
- Latency and throughput:
  - Byte present at cycle 0 → pop at cycle 0, pulse or register update at cycle 1, earliest push at cycle 2.
  - Maximum throughput is one command per 3 cycles (2 cycles with ECHO_EN=0 or for CR/LF).
- At most one button pulse is active at a time. Pulses never extend beyond one cycle.
- oRx_Pop is never asserted while iRx_Empty=1.
- oTx_Push is never asserted while iTx_Full=1.
- Toggles wrap naturally: toggling a bit twice restores it.
- Commands update outputs regardless of oCtrl_Mode; the mux decides whether they take effect.

Decomposition:
- Shared package holds: the FSM state enum (IDLE/EXEC/ACK), the command character constants (U, D, L, R, S, M, X, '0', CR, LF), the ACK/NAK defaults and MODE_W=5.
- One natural sub-module: uart_cmd_classify. It is purely combinational: byte in → one-hot command class plus mode index out, including the lowercase fold.
- The FSM and registers stay in the top module.

Test Plan:
- Reset then idle: iRst_n low for 3 cycles, RX empty → all outputs 0, no pop, no push.
- Byte 'U' (8'h55):
  - oRx_Pop=1 in cycle 0.
  - oPC_Btn_U=1 for exactly one cycle (cycle 1).
  - oTx_Push=1 with oTx_Data=8'h4B in cycle 2.
- Mode and select commands:
  - Sequence '2','4','m' → oPC_Mode=5'b10100 and oCtrl_Mode=1.
  - Then '2' → oPC_Mode=5'b10000.
  - Then 'X' → oPC_Mode=0, oPC_Set=0, oCtrl_Mode stays 1.
- Unrecognised and ignored bytes:
  - 8'h41 ('A') → no output change, one push of 8'h3F.
  - 8'h0D → no push; the FSM returns to IDLE in 2 cycles.
- TX backpressure:
  - iTx_Full=1 during ACK for 5 cycles, RX holds 'D','S' → no push and no further pop during those 5 cycles.
  - After iTx_Full falls: the 'D' ack is pushed, then 'S' is popped and oPC_Set becomes 1.
- Async reset during EXEC of 'S': oPC_Set stays 0, no ack is pushed, the FSM is in IDLE when iRst_n rises.
